instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Parametrised program sequencer driving the datapath instruction port. Replaces
//  fixed hard-coded opcode case tables with a loadable program memory, a run length,
//  a valid/stall handshake, loop mode and flag capture for carry-in.
//  Sits between the top-level test FSM/board logic and datapath (opCode, cin).
// PARAMETERS
//  INSTR_W   16  instruction word width (opcode in [INSTR_W-1:INSTR_W-4])
//  DEPTH     32  program memory entries
//  ADDR_W     5  pc/address width, 2**ADDR_W >= DEPTH
//  FLAG_W     5  datapath flag vector width
//  CARRY_BIT  3  index of carry within flags_in
//  COUNT_W   16  issued-instruction counter width
// PORTS
//  clk          in   1        clock, all state updates on rising edge
//  reset        in   1        synchronous, active-high
//  prog_we      in   1        program-memory write strobe
//  prog_addr    in   ADDR_W   write address
//  prog_data    in   INSTR_W  write data
//  prog_len     in   ADDR_W+1 instructions to run (sampled at start)
//  loop_en      in   1        1 = wrap to entry 0 after last instruction
//  start        in   1        begin run (IDLE/DONE only)
//  abort        in   1        synchronous stop, return to IDLE
//  stall        in   1        datapath not accepting this cycle
//  flags_in     in   FLAG_W   datapath flags for accepted instruction
//  instr_out    out  INSTR_W  instruction to datapath (opCode)
//  instr_valid  out  1        instr_out is live
//  cin_out      out  1        registered carry-in = flags_q[CARRY_BIT]
//  pc           out  ADDR_W   address of next instruction to fetch
//  busy         out  1        state == RUN
//  done         out  1        state == DONE
//  issue_count  out  COUNT_W  accepted instructions since start, saturating
// BEHAVIOUR
//  - States IDLE, RUN, DONE. Reset: IDLE; instr_out=0, instr_valid=0, cin_out=0,
//    pc=0, flags_q=0, issue_count=0, busy=0, done=0. Memory contents not cleared.
//  - prog_we writes mem[prog_addr] in IDLE/DONE only; ignored in RUN; addr>=DEPTH ignored.
//  - len = min(prog_len, DEPTH), latched at start.
//  - IDLE/DONE + start, len!=0: -> RUN; same edge instr_out<=mem[0], instr_valid<=1,
//    pc<=1 (len==1: pc<=0), issue_count<=0, done<=0. Latency start->valid: 1 cycle.
//  - IDLE/DONE + start, len==0: -> DONE, instr_valid stays 0, issue_count<=0.
//  - start while RUN ignored.
//  - Accept = instr_valid & !stall at an edge. Stall holds instr_out, instr_valid, pc.
//  - On accept: flags_q<=flags_in; cin_out<=flags_in[CARRY_BIT];
//    issue_count+1 (saturates at all-ones).
//  - Accept of non-last instruction: instr_out<=mem[pc], pc<=pc+1 (wrap to 0 at len).
//  - Accept of last (index len-1): loop_en=1 -> instr_out<=mem[0], pc<=1 (len==1: 0);
//    loop_en=0 -> instr_valid<=0, state DONE, done=1 held until start/reset.
//  - abort (any state) -> IDLE, instr_valid<=0, pc<=0; flags_q and issue_count kept.
//    reset has priority over abort, abort over start.
//  - loop_en sampled at each last-instruction accept (may change mid-run).
// CONFIGURATION
//  SEQ_HALT_EN defined: accepted instruction with opcode 4'hF ends run as if last
//    (DONE, instr_valid<=0) regardless of loop_en; halt word counted in issue_count.
//  SEQ_HALT_EN undefined: opcode 4'hF issued as an ordinary instruction.
// TESTING
//  1 Load mem[0..3]=5001,5101,0150,02D1; len=4, loop_en=0, start, stall=0 ->
//    valid 4 cycles in order, then done=1, issue_count=4, instr_valid=0.
//  2 Same program, stall=1 on 2nd valid cycle for 3 cycles -> instr_out holds 5101
//    for 4 cycles, no skip/duplicate, issue_count=4 at done.
//  3 len=3, loop_en=1 -> sequence mem0,1,2,0,1..; clear loop_en -> done after next mem2.
//  4 flags_in=5'b01000 on accept -> cin_out=1 next cycle; flags_in=0 with stall=1
//    -> cin_out unchanged.
//  5 abort during RUN at pc=2 -> IDLE, instr_valid=0 next cycle; prog_we in RUN
//    ignored; len=0 start -> done=1, no valid; reset mid-run -> all outputs reset.
//  6 SEQ_HALT_EN: mem[1]=F000, len=4 -> done after 2 accepts; undefined -> 4 accepts.

Source files
------------

// File: rtl/instr_sequencer.sv
// Loadable program sequencer: issues program memory words to the datapath with a
// valid/stall handshake, loop mode and carry capture. Optional macro: SEQ_HALT_EN.
module instr_sequencer #(
  parameter int INSTR_W   = 16,
  parameter int DEPTH     = 32,
  parameter int ADDR_W    = 5,
  parameter int FLAG_W    = 5,
  parameter int CARRY_BIT = 3,
  parameter int COUNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic [ADDR_W:0]    prog_len,
  input  logic               loop_en,
  input  logic               start,
  input  logic               abort,
  input  logic               stall,
  input  logic [FLAG_W-1:0]  flags_in,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  output logic               cin_out,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] issue_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t             r_state;
  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]    r_len;
  logic [FLAG_W-1:0]  r_flags;

  logic [ADDR_W:0]    w_len;
  logic [ADDR_W:0]    w_pc_inc;
  logic [ADDR_W-1:0]  w_pc_next;
  logic               w_accept;
  logic               w_last;
  logic               w_halt;

  assign w_len     = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
  assign w_accept  = instr_valid & ~stall;
  assign w_pc_inc  = {1'b0, pc} + 1'b1;
  assign w_pc_next = (w_pc_inc == r_len) ? '0 : w_pc_inc[ADDR_W-1:0];
  // pc always points one past the live word, so the live word is last exactly when pc wrapped to 0
  assign w_last    = (pc == '0);

`ifdef SEQ_HALT_EN
  assign w_halt = (instr_out[INSTR_W-1 -: 4] == 4'hF);
`else
  assign w_halt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (prog_we && r_state != S_RUN && {1'b0, prog_addr} < DEPTH_L)
      r_mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_flags     <= '0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      cin_out     <= 1'b0;
      pc          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      issue_count <= '0;
    end else if (abort) begin
      r_state     <= S_IDLE;
      instr_valid <= 1'b0;
      pc          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_len       <= w_len;
            issue_count <= '0;
            if (w_len != '0) begin
              r_state     <= S_RUN;
              instr_out   <= r_mem[0];
              instr_valid <= 1'b1;
              pc          <= (w_len == (ADDR_W+1)'(1)) ? '0 : ADDR_W'(1);
              busy        <= 1'b1;
              done        <= 1'b0;
            end else begin
              r_state <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_flags <= flags_in;
            cin_out <= flags_in[CARRY_BIT];
            if (issue_count != '1)
              issue_count <= issue_count + 1'b1;
            if (w_halt || (w_last && !loop_en)) begin
              r_state     <= S_DONE;
              instr_valid <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
            end else begin
              // looping after the last word reuses this path: pc==0 fetches mem[0]
              instr_out <= r_mem[pc];
              pc        <= w_pc_next;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed table-driven bench for instr_sequencer plus hand sequences for
// write-in-run, reset mid-run and the optional halt opcode.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset, prog_we, loop_en, start, abort, stall;
  logic [4:0]  prog_addr, flags_in;
  logic [15:0] prog_data;
  logic [5:0]  prog_len;
  logic [15:0] instr_out, issue_count;
  logic        instr_valid, cin_out, busy, done;
  logic [4:0]  pc;

  int nchk = 0;
  int nerr = 0;

  instr_sequencer dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .loop_en(loop_en), .start(start),
    .abort(abort), .stall(stall), .flags_in(flags_in), .instr_out(instr_out),
    .instr_valid(instr_valid), .cin_out(cin_out), .pc(pc), .busy(busy),
    .done(done), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  len;
    logic        lp, st, stl, ab;
    logic [4:0]  fl;
    logic        ev;
    logic [15:0] ei;
    logic [4:0]  epc;
    logic [15:0] ec;
    logic        ecin, eb, ed;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(int len, bit lp, bit st, bit stl, bit ab, logic [4:0] fl,
                              bit ev, logic [15:0] ei, int epc, int ec, bit ecin, bit eb, bit ed);
    vec_t v;
    v.len = 6'(len); v.lp = lp; v.st = st; v.stl = stl; v.ab = ab; v.fl = fl;
    v.ev = ev; v.ei = ei; v.epc = 5'(epc); v.ec = 16'(ec);
    v.ecin = ecin; v.eb = eb; v.ed = ed;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [4:0] a, logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  initial begin
    int n, guard;
    reset = 1'b1; prog_we = 0; prog_addr = 0; prog_data = 0; prog_len = 0;
    loop_en = 0; start = 0; abort = 0; stall = 0; flags_in = 0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr_out, 0);
    chk("rst_cin", cin_out, 0);
    chk("rst_pc", pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", issue_count, 0);

    wr(0, 16'h5001); wr(1, 16'h5101); wr(2, 16'h0150); wr(3, 16'h02D1);

    // len lp st stl ab fl | ev instr pc cnt cin busy done
    // plain run of 4
    vt.push_back(mk(4,0,1,0,0,5'h00, 1,16'h5001,1,0,0,1,0));
    vt.push_back(mk(4,0,0,0,0,5'h00, 1,16'h5101,2,1,0,1,0));
    vt.push_back(mk(4,0,0,0,0,5'h00, 1,16'h0150,3,2,0,1,0));
    vt.push_back(mk(4,0,0,0,0,5'h00, 1,16'h02D1,0,3,0,1,0));
    vt.push_back(mk(4,0,0,0,0,5'h00, 0,16'h0000,0,4,0,0,1));
    vt.push_back(mk(4,0,0,0,0,5'h00, 0,16'h0000,0,4,0,0,1));
    // stall on second word for 3 cycles, carry capture only on accept
    vt.push_back(mk(4,0,1,0,0,5'h00, 1,16'h5001,1,0,0,1,0));
    vt.push_back(mk(4,0,0,0,0,5'h08, 1,16'h5101,2,1,1,1,0));
    vt.push_back(mk(4,0,0,1,0,5'h00, 1,16'h5101,2,1,1,1,0));
    vt.push_back(mk(4,0,0,1,0,5'h00, 1,16'h5101,2,1,1,1,0));
    vt.push_back(mk(4,0,0,1,0,5'h00, 1,16'h5101,2,1,1,1,0));
    vt.push_back(mk(4,0,0,0,0,5'h00, 1,16'h0150,3,2,0,1,0));
    vt.push_back(mk(4,0,0,0,0,5'h17, 1,16'h02D1,0,3,0,1,0));
    vt.push_back(mk(4,0,0,0,0,5'h08, 0,16'h0000,0,4,1,0,1));
    // loop len 3, start ignored in run, loop_en cleared late
    vt.push_back(mk(3,1,1,0,0,5'h00, 1,16'h5001,1,0,1,1,0));
    vt.push_back(mk(3,1,0,0,0,5'h00, 1,16'h5101,2,1,0,1,0));
    vt.push_back(mk(3,1,0,0,0,5'h00, 1,16'h0150,0,2,0,1,0));
    vt.push_back(mk(3,1,0,0,0,5'h00, 1,16'h5001,1,3,0,1,0));
    vt.push_back(mk(3,1,1,0,0,5'h00, 1,16'h5101,2,4,0,1,0));
    vt.push_back(mk(3,1,0,0,0,5'h00, 1,16'h0150,0,5,0,1,0));
    vt.push_back(mk(3,1,0,0,0,5'h00, 1,16'h5001,1,6,0,1,0));
    vt.push_back(mk(3,0,0,0,0,5'h00, 1,16'h5101,2,7,0,1,0));
    vt.push_back(mk(3,0,0,0,0,5'h00, 1,16'h0150,0,8,0,1,0));
    vt.push_back(mk(3,0,0,0,0,5'h00, 0,16'h0000,0,9,0,0,1));
    // len 1, without and with loop
    vt.push_back(mk(1,0,1,0,0,5'h00, 1,16'h5001,0,0,0,1,0));
    vt.push_back(mk(1,0,0,0,0,5'h00, 0,16'h0000,0,1,0,0,1));
    vt.push_back(mk(1,1,1,0,0,5'h00, 1,16'h5001,0,0,0,1,0));
    vt.push_back(mk(1,1,0,0,0,5'h00, 1,16'h5001,0,1,0,1,0));
    vt.push_back(mk(1,0,0,0,0,5'h00, 0,16'h0000,0,2,0,0,1));
    // abort at pc=2 (beats a simultaneous start), then len 0
    vt.push_back(mk(4,0,1,0,0,5'h00, 1,16'h5001,1,0,0,1,0));
    vt.push_back(mk(4,0,0,0,0,5'h00, 1,16'h5101,2,1,0,1,0));
    vt.push_back(mk(4,0,1,0,1,5'h00, 0,16'h0000,0,1,0,0,0));
    vt.push_back(mk(4,0,0,0,0,5'h00, 0,16'h0000,0,1,0,0,0));
    vt.push_back(mk(0,0,1,0,0,5'h00, 0,16'h0000,0,0,0,0,1));
    vt.push_back(mk(0,0,0,0,0,5'h00, 0,16'h0000,0,0,0,0,1));

    for (int i = 0; i < vt.size(); i++) begin
      prog_len = vt[i].len; loop_en = vt[i].lp; start = vt[i].st;
      stall = vt[i].stl; abort = vt[i].ab; flags_in = vt[i].fl;
      tick();
      chk($sformatf("v%0d_valid", i), instr_valid, vt[i].ev);
      chk($sformatf("v%0d_count", i), issue_count, vt[i].ec);
      chk($sformatf("v%0d_cin", i), cin_out, vt[i].ecin);
      chk($sformatf("v%0d_busy", i), busy, vt[i].eb);
      chk($sformatf("v%0d_done", i), done, vt[i].ed);
      if (vt[i].ev) chk($sformatf("v%0d_instr", i), instr_out, vt[i].ei);
      if (vt[i].ev || vt[i].ab) chk($sformatf("v%0d_pc", i), pc, vt[i].epc);
    end
    start = 0; abort = 0; stall = 0; flags_in = 0;

    // program writes ignored while running, honoured when done
    prog_len = 2; loop_en = 0; start = 1;
    tick();
    start = 0;
    stall = 1; prog_we = 1; prog_addr = 1; prog_data = 16'hABCD;
    tick();
    prog_we = 0; stall = 0;
    chk("wrun_hold", instr_out, 16'h5001);
    tick();
    chk("wrun_ignored", instr_out, 16'h5101);
    tick();
    chk("wrun_done", done, 1);
    wr(1, 16'hABCD);
    start = 1;
    tick();
    start = 0;
    tick();
    chk("wdone_written", instr_out, 16'hABCD);
    tick();

    // reset mid-run
    prog_len = 4; start = 1;
    tick();
    start = 0; flags_in = 5'h08;
    tick();
    flags_in = 0;
    chk("pre_rst_cin", cin_out, 1);
    reset = 1;
    tick();
    reset = 0;
    chk("mrst_valid", instr_valid, 0);
    chk("mrst_instr", instr_out, 0);
    chk("mrst_cin", cin_out, 0);
    chk("mrst_pc", pc, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_count", issue_count, 0);

    // halt opcode in the middle of a 4-word program
    wr(1, 16'hF000);
    prog_len = 4; loop_en = 0; start = 1;
    tick();
    start = 0;
    n = 0; guard = 0;
    while (busy && guard < 20) begin
      if (instr_valid) n++;
      tick();
      guard++;
    end
    chk("halt_timeout", (guard < 20), 1);
`ifdef SEQ_HALT_EN
    chk("halt_accepts", n, 2);
    chk("halt_count", issue_count, 2);
`else
    chk("halt_accepts", n, 4);
    chk("halt_count", issue_count, 4);
`endif
    chk("halt_done", done, 1);
    chk("halt_valid", instr_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
